// File: rtl/serial_link_floo_vc_arbiter_if.sv
// Flit handshake bundle between the NoC channels and the AXIS transmit port.
// The DUT takes the slave view; the channel/link side takes the master view.
interface serial_link_floo_vc_arbiter_if #(
  parameter int unsigned NumChan   = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ChanIdxW  = $clog2(NumChan)
);
  logic [NumChan-1:0]           chan_valid_i;
  logic [NumChan-1:0]           chan_ready_o;
  logic [NumChan*DataWidth-1:0] chan_data_i;
  logic                         axis_tvalid_o;
  logic                         axis_tready_i;
  logic [DataWidth-1:0]         axis_tdata_o;
  logic [ChanIdxW-1:0]          axis_tchan_o;

  modport slave (
    input  chan_valid_i, chan_data_i, axis_tready_i,
    output chan_ready_o, axis_tvalid_o, axis_tdata_o, axis_tchan_o
  );

  modport master (
    output chan_valid_i, chan_data_i, axis_tready_i,
    input  chan_ready_o, axis_tvalid_o, axis_tdata_o, axis_tchan_o
  );
endinterface

// File: rtl/serial_link_floo_vc_arbiter.sv
// Credit-based round-robin VC scheduler feeding one registered AXIS stream.
// A channel is only granted while it holds a credit for the far-side buffer.
module serial_link_floo_vc_arbiter #(
  parameter int unsigned NumChan   = 2,
  parameter int unsigned NumCred   = 8,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned ChanIdxW = $clog2(NumChan),
  localparam int unsigned CredW    = $clog2(NumCred + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  serial_link_floo_vc_arbiter_if.slave bus,
  input  logic [NumChan-1:0]       cred_ret_valid_i,
  output logic [NumChan*CredW-1:0] credit_o,
  output logic                     cred_err_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [ChanIdxW-1:0]  chan_q, chan_d;
  logic [ChanIdxW-1:0]  ptr_q, ptr_d;
  logic [CredW-1:0]     cred_q [NumChan];
  logic [CredW-1:0]     cred_d [NumChan];
  logic                 err_q, err_d;

  logic [NumChan-1:0]   elig;
  logic [NumChan-1:0]   gnt;
  logic [ChanIdxW-1:0]  gnt_idx;
  logic [ChanIdxW-1:0]  cand;
  logic                 gnt_vld;
  logic                 load_en;

  assign load_en = (state_q == EMPTY) || bus.axis_tready_i;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NumChan; i++) begin
      elig[i] = bus.chan_valid_i[i] && (cred_q[i] != '0);
    end
  end

  // First eligible channel at or after the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NumChan; k++) begin
      cand = ChanIdxW'((32'(ptr_q) + 32'(k)) % NumChan);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vld = gnt_vld && load_en && rst_ni;
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  assign bus.chan_ready_o = gnt;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (gnt_vld) begin
      state_d = FULL;
      data_d  = bus.chan_data_i[32'(gnt_idx)*DataWidth +: DataWidth];
      chan_d  = gnt_idx;
      ptr_d   = (gnt_idx == ChanIdxW'(NumChan - 1)) ? '0
                                                    : gnt_idx + 1'b1;
    end else if (load_en) begin
      state_d = EMPTY;
    end
  end

  // A simultaneous grant and return cancel out.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NumChan; i++) begin
      cred_d[i] = cred_q[i];
      unique case ({gnt[i], cred_ret_valid_i[i]})
        2'b10: cred_d[i] = cred_q[i] - 1'b1;
        2'b01: begin
          if (cred_q[i] == CredW'(NumCred)) err_d = 1'b1;
          else cred_d[i] = cred_q[i] + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    credit_o = '0;
    for (int i = 0; i < NumChan; i++) begin
      credit_o[i*CredW +: CredW] = cred_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NumChan; i++) cred_q[i] <= CredW'(NumCred);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int i = 0; i < NumChan; i++) cred_q[i] <= cred_d[i];
    end
  end

  assign bus.axis_tvalid_o = (state_q == FULL);
  assign bus.axis_tdata_o  = data_q;
  assign bus.axis_tchan_o  = chan_q;
  assign cred_err_o        = err_q;

endmodule

// File: tb/tb_serial_link_floo_vc_arbiter.sv
// Bench for the VC arbiter: credit/round-robin model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_serial_link_floo_vc_arbiter;
  localparam int NCH = 2;
  localparam int NCRED = 8;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NCH-1:0] cred_ret;
  logic [NCH*4-1:0] credit;
  logic cred_err;

  always #5 clk = ~clk;

  serial_link_floo_vc_arbiter_if #(.NumChan(NCH), .DataWidth(DW)) bus ();

  serial_link_floo_vc_arbiter #(
    .NumChan(NCH), .NumCred(NCRED), .DataWidth(DW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .bus(bus),
    .cred_ret_valid_i(cred_ret),
    .credit_o(credit),
    .cred_err_o(cred_err)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  int m_cred [NCH];
  int m_ptr;
  bit m_full;
  logic [DW-1:0] m_data;
  int m_chan;
  bit m_err;
  bit m_ok = 1'b0;
  int m_g;
  int gq[$];

  // Closest eligible channel by distance from the pointer.
  function automatic int pick_f(input logic [NCH-1:0] v, input int c0,
                                input int c1, input int ptr,
                                input bit full, input logic rdy,
                                input logic rst);
    int best, bestd, d, cr;
    best = -1;
    bestd = NCH;
    if (!rst || (full && !rdy)) return -1;
    for (int c = 0; c < NCH; c++) begin
      cr = (c == 0) ? c0 : c1;
      d = (c - ptr + NCH) % NCH;
      if (v[c] && cr > 0 && d < bestd) begin
        bestd = d;
        best = c;
      end
    end
    return best;
  endfunction

  always_comb m_g = pick_f(bus.chan_valid_i, m_cred[0], m_cred[1], m_ptr,
                           m_full, bus.axis_tready_i, rst_ni);

  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++) m_cred[c] <= NCRED;
      m_ptr <= 0;
      m_full <= 1'b0;
      m_data <= '0;
      m_chan <= 0;
      m_err <= 1'b0;
      m_ok <= 1'b1;
    end else begin
      if (m_g >= 0) begin
        m_full <= 1'b1;
        m_data <= bus.chan_data_i[m_g*DW +: DW];
        m_chan <= m_g;
        m_ptr <= (m_g + 1) % NCH;
        gq.push_back(m_g);
      end else if (bus.axis_tready_i) begin
        m_full <= 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (m_g == c && !cred_ret[c]) m_cred[c] <= m_cred[c] - 1;
        else if (cred_ret[c] && m_g != c) begin
          if (m_cred[c] == NCRED) m_err <= 1'b1;
          else m_cred[c] <= m_cred[c] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("chan_ready", 64'(bus.chan_ready_o),
          (m_g >= 0) ? 64'(1 << m_g) : 64'd0);
      chk("tvalid", 64'(bus.axis_tvalid_o), 64'(m_full));
      if (m_full) begin
        chk("tdata", bus.axis_tdata_o, m_data);
        chk("tchan", 64'(bus.axis_tchan_o), 64'(m_chan));
      end
      chk("credit", 64'(credit), 64'({4'(m_cred[1]), 4'(m_cred[0])}));
      chk("cred_err", 64'(cred_err), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus.chan_valid_i = '0;
    cred_ret = '0;
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.chan_valid_i = '0;
    bus.chan_data_i = '0;
    bus.axis_tready_i = 1'b0;
    cred_ret = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    chk("rst_credit", 64'(credit), 64'h88);
    chk("rst_tvalid", 64'(bus.axis_tvalid_o), 64'd0);
    chk("rst_tdata", bus.axis_tdata_o, 64'd0);
    chk("rst_tchan", 64'(bus.axis_tchan_o), 64'd0);
    chk("rst_err", 64'(cred_err), 64'd0);

    // 1: both valid, credits drain to zero
    gq.delete();
    bus.chan_valid_i = 2'b11;
    bus.axis_tready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.chan_data_i = {64'(200 + i), 64'(100 + i)};
      tick();
      if (i == 15) begin
        chk("t1_cred0", 64'(credit), 64'h00);
        chk("t1_tv_last", 64'(bus.axis_tvalid_o), 64'd1);
      end
      if (i == 16) chk("t1_tv_drop", 64'(bus.axis_tvalid_o), 64'd0);
    end
    chk("t1_ngnt", 64'(gq.size()), 64'd16);
    chk("t1_g0", 64'(gq[0]), 64'd0);
    chk("t1_g1", 64'(gq[1]), 64'd1);
    chk("t1_g2", 64'(gq[2]), 64'd0);
    chk("t1_g3", 64'(gq[3]), 64'd1);
    chk("t1_ready", 64'(bus.chan_ready_o), 64'd0);

    // 2: channel 0 with a return every cycle
    do_reset();
    gq.delete();
    bus.chan_valid_i = 2'b01;
    cred_ret = 2'b01;
    for (int i = 0; i < 10; i++) begin
      bus.chan_data_i = {64'd0, 64'(300 + i)};
      tick();
    end
    chk("t2_ngnt", 64'(gq.size()), 64'd10);
    chk("t2_credit", 64'(credit), 64'h88);
    chk("t2_tchan", 64'(bus.axis_tchan_o), 64'd0);
    chk("t2_tdata", bus.axis_tdata_o, 64'(309));
    bus.chan_valid_i = '0;
    cred_ret = '0;
    tick();
    tick();

    // 3: FULL with 0xA5 on channel 1 held under backpressure
    bus.chan_valid_i = 2'b10;
    bus.chan_data_i = {64'hA5, 64'd0};
    bus.axis_tready_i = 1'b0;
    tick();
    bus.chan_valid_i = 2'b01;
    bus.chan_data_i = {64'd0, 64'h5A};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_ready_hold", 64'(bus.chan_ready_o), 64'd0);
      chk("t3_tdata_hold", bus.axis_tdata_o, 64'hA5);
      chk("t3_tchan_hold", 64'(bus.axis_tchan_o), 64'd1);
      tick();
    end
    bus.axis_tready_i = 1'b1;
    #1;
    chk("t3_ready_rel", 64'(bus.chan_ready_o), 64'd1);
    tick();
    chk("t3_tdata_new", bus.axis_tdata_o, 64'h5A);
    chk("t3_tchan_new", 64'(bus.axis_tchan_o), 64'd0);
    bus.chan_valid_i = '0;
    tick();
    tick();

    // 4: channel 1 starved of credit, pointer at 1
    bus.chan_valid_i = 2'b10;
    for (int i = 0; i < 7; i++) tick();
    bus.chan_valid_i = 2'b01;
    tick();
    chk("t4_credit_pre", 64'(credit), 64'h06);
    bus.chan_valid_i = 2'b11;
    gq.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_ready_c0", 64'(bus.chan_ready_o), 64'd1);
      tick();
    end
    cred_ret = 2'b10;
    tick();
    cred_ret = '0;
    #1;
    chk("t4_ready_c1", 64'(bus.chan_ready_o), 64'd2);
    tick();
    chk("t4_seq", 64'({gq[0], gq[1], gq[2], gq[3], gq[4]}), 64'd1);
    chk("t4_credit", 64'(credit), 64'h02);
    bus.chan_valid_i = '0;
    tick();
    tick();

    // 5: overflow return sets sticky error
    do_reset();
    cred_ret = 2'b01;
    tick();
    cred_ret = '0;
    chk("t5_err", 64'(cred_err), 64'd1);
    chk("t5_credit", 64'(credit), 64'h88);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_err_sticky", 64'(cred_err), 64'd1);

    // 6: reset while FULL with credits {5,3}
    bus.chan_valid_i = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    bus.chan_valid_i = 2'b01;
    tick();
    tick();
    chk("t6_credit_pre", 64'(credit), 64'h53);
    chk("t6_tv_pre", 64'(bus.axis_tvalid_o), 64'd1);
    rst_ni = 1'b0;
    bus.chan_valid_i = 2'b11;
    bus.axis_tready_i = 1'b0;
    #1;
    chk("t6_ready_rst", 64'(bus.chan_ready_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    chk("t6_tvalid", 64'(bus.axis_tvalid_o), 64'd0);
    chk("t6_credit", 64'(credit), 64'h88);
    chk("t6_err", 64'(cred_err), 64'd0);
    bus.axis_tready_i = 1'b1;
    #1;
    chk("t6_first_gnt", 64'(bus.chan_ready_o), 64'd1);
    tick();
    chk("t6_tchan", 64'(bus.axis_tchan_o), 64'd0);
    chk("t6_tv", 64'(bus.axis_tvalid_o), 64'd1);
    bus.chan_valid_i = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
